// File: rtl/sc_stream_gen.sv
// Stochastic-computing bitstream generator: takes one quota per stream and emits
// a BITSTREAM-bit unipolar stream with exactly that many ones, spread evenly.
module sc_stream_gen #(
  parameter  int BITSTREAM = 64,
  localparam int QW        = $clog2(BITSTREAM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] quota,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          bit_out,
  output logic          bit_last,
  output logic          busy
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // The accumulator gets one extra bit so that acc + quota never wraps
  // before it is compared against the stream length.
  localparam logic [QW:0]   T_W      = (QW+1)'(BITSTREAM);
  localparam logic [QW-1:0] LAST_IDX = QW'(BITSTREAM - 1);

  state_t        state, state_nx;
  logic [QW-1:0] q_reg, q_nx;
  logic [QW-1:0] idx, idx_nx;
  logic [QW:0]   acc, acc_nx;

  logic [QW:0]   sum;
  logic          sat;
  logic          bit_raw;
  logic          fire;
  logic          load;

  // Output decode depends only on registered state, never on in_valid.
  assign sum       = acc + {1'b0, q_reg};
  assign sat       = ({1'b0, q_reg} >= T_W);
  assign bit_raw   = sat || (sum >= T_W);

  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign bit_out   = out_valid && bit_raw;
  assign bit_last  = out_valid && (idx == LAST_IDX);

  assign fire      = out_valid && out_ready;
  assign in_ready  = (state == IDLE) || (fire && bit_last);
  assign load      = in_valid && in_ready;

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    q_nx     = q_reg;
    idx_nx   = idx;
    acc_nx   = acc;

    unique case (state)
      IDLE: begin
        if (load) begin
          state_nx = STREAM;
          q_nx     = quota;
          idx_nx   = '0;
          acc_nx   = '0;
        end
      end

      STREAM: begin
        if (fire) begin
          if (bit_last) begin
            // Final bit: chain straight into the next stream when one is offered.
            idx_nx = '0;
            acc_nx = '0;
            if (in_valid) begin
              q_nx = quota;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            idx_nx = idx + QW'(1);
            if (sat) begin
              acc_nx = '0;
            end else if (bit_raw) begin
              acc_nx = sum - T_W;
            end else begin
              acc_nx = sum;
            end
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q_reg <= '0;
      idx   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      q_reg <= q_nx;
      idx   <= idx_nx;
      acc   <= acc_nx;
    end
  end

endmodule

// File: tb/tb_sc_stream_gen.sv
// Self-checking bench for sc_stream_gen: table-driven directed streams, chained
// and reset corner cases, randomized streams, and a full quota sweep.
module tb_sc_stream_gen;

  localparam int T  = 64;
  localparam int QW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] quota;
  logic          out_valid;
  logic          out_ready;
  logic          bit_out;
  logic          bit_last;
  logic          busy;

  int total = 0;
  int bad   = 0;

  sc_stream_gen #(.BITSTREAM(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quota     (quota),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bit_out   (bit_out),
    .bit_last  (bit_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int ready_pct;
    int exp_ones;
    int first_one;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit k of an evenly spread stream with q ones in T slots is set exactly
  // when floor((k+1)q/T) steps past floor(kq/T).
  function automatic logic model_bit(input int q, input int k);
    return (((k + 1) * q) / T - (k * q) / T) != 0;
  endfunction

  task automatic start_stream(input int q);
    @(negedge clk);
    in_valid = 1'b1;
    quota    = QW'(q);
    out_ready = 1'b0;
    #1;
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk);
  endtask

  // Consume stop_at bits of a running stream, checking every sampled cycle.
  task automatic drain(input int q, input int ready_pct, input bit chain, input int next_q,
                       input int stop_at, output logic [63:0] bits, output int ones);
    int   i       = 0;
    int   cyc     = 0;
    bit   stalled = 1'b0;
    logic prev_bit = 1'b0;
    logic rdy;
    bits = '0;
    ones = 0;
    while (i < stop_at) begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        check("timeout", 64'(i), 64'(stop_at));
        break;
      end
      rdy       = ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      in_valid  = chain;
      quota     = chain ? QW'(next_q) : '0;
      #1;
      check("valid", out_valid, 1'b1);
      check("bit", bit_out, model_bit(q, i));
      check("last", bit_last, (i == T - 1));
      check("in_ready", in_ready, rdy && (i == T - 1));
      if (stalled) check("hold", bit_out, prev_bit);
      prev_bit = bit_out;
      stalled  = !rdy;
      if (rdy && out_valid) begin
        bits[i] = bit_out;
        ones   += int'(bit_out);
        i++;
      end
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_ready", in_ready, 1'b1);
    check("idle_valid", out_valid, 1'b0);
    check("idle_last", bit_last, 1'b0);
  endtask

  initial begin
    logic [63:0] bits;
    logic [63:0] ref_bits;
    int          ones;
    int          first;
    int          q;
    int          nq;
    bit          pending;
    bit          chain;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; quota = '0;
    ref_bits = '0;
    #2;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_bit", bit_out, 1'b0);
    check("rst_last", bit_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{q: 0,  ready_pct: 100, exp_ones: 0,  first_one: -1};
    vecs[1] = '{q: 1,  ready_pct: 100, exp_ones: 1,  first_one: 63};
    vecs[2] = '{q: 63, ready_pct: 100, exp_ones: 63, first_one: 1};
    vecs[3] = '{q: 32, ready_pct: 100, exp_ones: 32, first_one: 1};
    vecs[4] = '{q: 21, ready_pct: 100, exp_ones: 21, first_one: 3};
    vecs[5] = '{q: 21, ready_pct: 50,  exp_ones: 21, first_one: 3};

    foreach (vecs[v]) begin
      start_stream(vecs[v].q);
      drain(vecs[v].q, vecs[v].ready_pct, 1'b0, 0, T, bits, ones);
      check("vec_ones", 64'(ones), 64'(vecs[v].exp_ones));
      first = -1;
      for (int k = T - 1; k >= 0; k--) if (bits[k]) first = k;
      check("vec_first_one", 64'(first), 64'(vecs[v].first_one));
      if (vecs[v].q == 32) check("alt_pattern", bits, 64'hAAAA_AAAA_AAAA_AAAA);
      if (vecs[v].q == 21 && vecs[v].ready_pct == 100) ref_bits = bits;
      if (vecs[v].q == 21 && vecs[v].ready_pct < 100) check("bp_same_bits", bits, ref_bits);
      idle_check();
    end

    // Back-to-back streams with in_valid held high through the first one.
    start_stream(5);
    drain(5, 100, 1'b1, 40, T, bits, ones);
    check("b2b_ones_a", 64'(ones), 64'd5);
    drain(40, 100, 1'b0, 0, T, bits, ones);
    check("b2b_ones_b", 64'(ones), 64'd40);
    idle_check();

    // Asynchronous reset in the middle of a stream, away from any clock edge.
    start_stream(50);
    drain(50, 100, 1'b0, 0, 17, bits, ones);
    @(negedge clk);
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1'b1);
    start_stream(7);
    drain(7, 100, 1'b0, 0, T, bits, ones);
    check("post_rst_ones", 64'(ones), 64'd7);
    idle_check();

    // Randomized streams, some chained, with random backpressure.
    pending = 1'b0;
    q = $urandom_range(T - 1);
    for (int n = 0; n < 20; n++) begin
      if (!pending) start_stream(q);
      chain = (n < 19) && ($urandom_range(1) == 1);
      nq    = $urandom_range(T - 1);
      drain(q, $urandom_range(100, 20), chain, nq, T, bits, ones);
      check("rand_ones", 64'(ones), 64'(q));
      if (!chain) idle_check();
      pending = chain;
      q = chain ? nq : $urandom_range(T - 1);
    end

    for (int s = 0; s < T; s++) begin
      start_stream(s);
      drain(s, 100, 1'b0, 0, T, bits, ones);
      check("sweep_ones", 64'(ones), 64'(s));
      idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_stream_gen.md
# sc_stream_gen

Stochastic-computing bitstream generator that sits directly downstream of the quota converter. It accepts one quota value (number of ones) per stream over a valid/ready handshake. It then serially emits a BITSTREAM-bit unipolar stream containing exactly that many ones. The ones are spread evenly using a Weyl-accumulator (carry-out) ordering, and the stream is delivered over a valid/ready output handshake to the stochastic datapath.

## Interface
- BITSTREAM, 64, stream length T in bits; any value ≥ 2.
- QW, $clog2(BITSTREAM), quota width; derived, do not override.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  quota on `quota` is valid.
- in_ready  output  1  block can accept a quota this cycle.
- quota  input  QW  number of ones in the stream, 0..2^QW-1, interpreted unsigned.
- out_valid  output  1  `bit_out` holds a valid stream bit.
- out_ready  input  1  consumer accepts the current bit.
- bit_out  output  1  current stream bit.
- bit_last  output  1  current bit is stream index T-1.
- busy  output  1  a stream is in progress (state STREAM).

## Operation
- Registers:
  - q_reg[QW-1:0]: latched quota.
  - acc: Weyl accumulator, range 0..T-1, width QW+1 internally for compare.
  - idx: bit index, range 0..T-1.
  - state: IDLE or STREAM.
- Bit rule:
  - sum = acc + q_reg, computed at QW+1 bits with no truncation.
  - bit_out = (sum ≥ T).
  - On each output handshake, acc ← bit_out ? sum − T : sum.
- acc starts each stream at 0. Total ones over T bits is therefore exactly q_reg for any q_reg < T. If q_reg ≥ T (only possible for non-power-of-two T), the result is saturating, with all ones emitted.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: q_reg←quota, acc←0, idx←0, go to STREAM.
- STREAM:
  - out_valid=1.
  - On out_valid&&out_ready: idx←idx+1 and acc updated as above.
  - bit_last = (idx == T−1).
  - On the handshake with bit_last=1:
    - if in_valid, load the new quota (acc←0, idx←0) and stay in STREAM (back-to-back);
    - otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && bit_last). This is combinational from out_ready, with no combinational path from in_valid.
- While out_ready=0: bit_out, bit_last, acc, idx and q_reg are all held stable, and in_ready=0 in STREAM.
- in_valid during STREAM, other than on the final handshake, is ignored. The quota is not consumed.

## Timing
- Reset values:
  - state=IDLE, busy=0, out_valid=0, bit_out=0, bit_last=0, in_ready=1.
  - q_reg=0, acc=0, idx=0.
- Reset asserted mid-stream aborts the stream immediately, asynchronously. No partial-stream flush occurs. The first cycle after deassertion behaves as IDLE.
- Latency:
  - A quota accepted at edge N gives out_valid=1 with index 0 after edge N.
  - With out_ready held high, a stream occupies exactly T cycles.
  - Back-to-back streams give T bits per T cycles with no bubble.
  - An isolated quota costs 1 idle cycle (accept) plus T stream cycles.
- bit_out and bit_last are combinational from registers only (acc, q_reg, idx, state). They have no input-to-output path.
- Output handshake rule: once out_valid=1, it stays 1 and bit_out stays stable until the handshake completes.

## Test plan
- T=64, quota=0 → 64 bits all 0; bit_last only on the 64th; then in_ready=1 and busy=0.
- T=64, quota=1 → single 1 at index 63. quota=63 → single 0 at index 0, ones count 63.
- T=64, quota=32 → pattern 0,1,0,1,… starting with 0 at index 0; ones count 32.
- Random out_ready backpressure (≈50% duty), quota=21 → bit sequence identical to the no-backpressure run; bits held stable while stalled; ones count 21.
- Back-to-back quotas 5 then 40 with in_valid held high → 128 consecutive valid cycles with no gap; per-stream ones counts 5 and 40; in_ready pulses only on the index-63 handshake.
- rst asserted at index 17 of a quota=50 stream → out_valid drops without waiting for a clock edge; after release, in_ready=1; next quota=7 stream is correct from index 0.
- Full sweep: quota 0..63 each checked for ones count == quota, and against a model with acc=0, sum=acc+q, bit=(sum≥64), acc=sum mod 64.
